// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} sweep_state_t;

  localparam int N_VEC = 16;  // input combinations of a 4-input function
  localparam int N_IN  = 4;   // width of the applied vector

endpackage : sweep_pkg

// File: rtl/hold_timer.sv
// Hold timer: 8-bit dwell counter that ticks on the last clock of each hold.
// Latency: tick_o asserts while the count equals HOLD_CYCLES-1 (registered count).
// Backpressure: none; counts whenever en_i is high, clr_i has priority.
// Ports:
//   clk, reset_b : clock and asynchronous active-low reset
//   clr_i        : synchronous clear of the count
//   en_i         : advance the count this clock
//   tick_o       : count has reached HOLD_CYCLES-1
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Wrap to zero on the sampling clock so the next vector gets a full hold.
      cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : hold_timer

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps abcd through 0..15, holds each vector HOLD_CYCLES
// clocks and captures f on the last clock of each hold into a minterm vector.
// Latency: 16*HOLD_CYCLES clocks from the start edge to the done pulse; all outputs registered.
// Backpressure: none; start is only accepted when idle (or on the exit edge of DONE).
// Ports:
//   clk, reset_b  : clock and asynchronous active-low reset
//   start         : sweep request
//   f             : response of the block under sweep
//   abcd          : applied vector (abcd[3]=a .. abcd[0]=d)
//   busy / done   : sweep in progress / one-cycle completion pulse
//   tt            : captured truth table, tt[k] = f at abcd=k
//   minterm_count : number of ones in tt
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             f,
  output logic [N_IN-1:0]  abcd,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] tt,
  output logic [4:0]       minterm_count
);

  sweep_state_t     state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_VEC-1:0] tt_q, tt_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]  abcd_q, abcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // The timer only runs in DRIVE and is held at zero otherwise, so the first
  // vector of every sweep starts from a clean count.
  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .clr_i   (state_q != DRIVE),
    .en_i    (state_q == DRIVE),
    .tick_o  (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          tt_d    = '0;
          cnt_d   = '0;
        end
      end

      DRIVE: begin
        if (tick) begin
          tt_d[idx_q] = f;
          cnt_d       = cnt_q + 5'(f);
          if (idx_q == N_IN'(N_VEC - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        // DONE falls through IDLE on its exit edge: a start seen on that edge
        // launches the next sweep directly, giving a 16H+1 cycle repeat rate.
        state_d = IDLE;
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          tt_d    = '0;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of lag.
    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
    abcd_d = (state_d == DRIVE) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
      cnt_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      cnt_q   <= cnt_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign abcd          = abcd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign tt            = tt_q;
  assign minterm_count = cnt_q;

endmodule : truth_table_sweeper
